// File: rtl/timer_unit.sv
// timer_unit: one 8051 timer/counter channel (TLx/THx, TMOD nibble, TRx/TFx) on the SFR bus
module timer_unit #(
    parameter int         TIMER_ID  = 0,
    parameter logic [7:0] TL_ADDR   = 8'h8A,
    parameter logic [7:0] TH_ADDR   = 8'h8C,
    parameter logic [7:0] TMOD_ADDR = 8'h89,
    parameter logic [7:0] TCON_ADDR = 8'h88
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic [7:0] addr,
    input  logic       wr_en,
    input  logic       wr_bit_en,
    input  logic       bit_in,
    input  logic       tick,
    input  logic       t_pin,
    input  logic       int_pin,
    input  logic       tf_clear,
    output logic [7:0] tl_data,
    output logic [7:0] th_data,
    output logic [3:0] tmod_nib,
    output logic       tr,
    output logic       tf
);
    localparam int TRB = 4 + 2 * TIMER_ID;
    localparam int TFB = 5 + 2 * TIMER_ID;
    localparam logic [7:0] TR_ADDR = TCON_ADDR + 8'(TRB);
    localparam logic [7:0] TF_ADDR = TCON_ADDR + 8'(TFB);

    logic [1:0]  sync;
    logic        sample;
    logic        byte_wr, bit_wr, wr_tl, wr_th, wr_tmod, tr_wr, tf_wr, tr_val, tf_val;
    logic        fall, pulse, count, ovf_raw, ovf;
    logic [7:0]  ntl, nth;
    logic [12:0] c13;
    logic [15:0] c16;

    assign byte_wr = wr_en & ~wr_bit_en;
    assign bit_wr  = wr_en & wr_bit_en;
    assign wr_tl   = byte_wr & (addr == TL_ADDR);
    assign wr_th   = byte_wr & (addr == TH_ADDR);
    assign wr_tmod = byte_wr & (addr == TMOD_ADDR);
    assign tr_wr   = byte_wr & (addr == TCON_ADDR) | bit_wr & (addr == TR_ADDR);
    assign tf_wr   = byte_wr & (addr == TCON_ADDR) | bit_wr & (addr == TF_ADDR);
    assign tr_val  = wr_bit_en ? bit_in : data_in[TRB];
    assign tf_val  = wr_bit_en ? bit_in : data_in[TFB];

    assign fall  = tick & sample & ~sync[1];
    assign pulse = tr & (~tmod_nib[3] | int_pin) & (tmod_nib[2] ? fall : tick);
    // a software load of either count register suppresses that cycle's increment entirely
    assign count = pulse & ~wr_tl & ~wr_th;
    assign ovf   = count & ovf_raw;

    assign c13 = {th_data, tl_data[4:0]} + 13'd1;
    assign c16 = {th_data, tl_data} + 16'd1;

    always_comb begin
        ntl = tl_data;
        nth = th_data;
        ovf_raw = 1'b0;
        case (tmod_nib[1:0])
            2'b00: begin
                {nth, ntl[4:0]} = c13;
                ovf_raw = &{th_data, tl_data[4:0]};
            end
            2'b01: begin
                {nth, ntl} = c16;
                ovf_raw = &{th_data, tl_data};
            end
            2'b10: begin
                ntl = &tl_data ? th_data : tl_data + 8'd1;
                ovf_raw = &tl_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync     <= '0;
            sample   <= 1'b0;
            tl_data  <= '0;
            th_data  <= '0;
            tmod_nib <= '0;
            tr       <= 1'b0;
            tf       <= 1'b0;
        end else begin
            sync    <= {sync[0], t_pin};
            sample  <= tick ? sync[1] : sample;
            tl_data <= wr_tl ? data_in : count ? ntl : tl_data;
            th_data <= wr_th ? data_in : count ? nth : th_data;
            if (wr_tmod)
                tmod_nib <= data_in[4*TIMER_ID +: 4];
            if (tr_wr)
                tr <= tr_val;
            // hardware set beats acknowledge, acknowledge beats software write
            tf <= ovf | (~tf_clear & (tf_wr ? tf_val : tf));
        end
    end
endmodule

// File: tb/tb_timer_unit.sv
// tb_timer_unit: directed plus randomized checks of timer_unit (channel 1) against a behavioural model
module tb_timer_unit;
    localparam int ID = 1;
    localparam logic [7:0] TL_A = 8'h8B, TH_A = 8'h8D, TMOD_A = 8'h89, TCON_A = 8'h88;
    localparam logic [7:0] TR_A = 8'h8E, TF_A = 8'h8F;
    localparam logic [7:0] ADDRS [8] = '{TL_A, TH_A, TMOD_A, TCON_A, TR_A, TF_A, 8'h8A, 8'h8C};

    logic clock = 1'b0, reset;
    logic [7:0] data_in = '0, addr = '0;
    logic wr_en = 0, wr_bit_en = 0, bit_in = 0, tick = 0, t_pin = 0, int_pin = 0, tf_clear = 0;
    logic [7:0] tl_data, th_data;
    logic [3:0] tmod_nib;
    logic tr, tf;

    int n_cmp = 0, n_err = 0;

    timer_unit #(.TIMER_ID(ID), .TL_ADDR(TL_A), .TH_ADDR(TH_A), .TMOD_ADDR(TMOD_A), .TCON_ADDR(TCON_A)) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .addr(addr), .wr_en(wr_en),
        .wr_bit_en(wr_bit_en), .bit_in(bit_in), .tick(tick), .t_pin(t_pin), .int_pin(int_pin),
        .tf_clear(tf_clear), .tl_data(tl_data), .th_data(th_data), .tmod_nib(tmod_nib), .tr(tr), .tf(tf)
    );

    always #5 clock = ~clock;

    int m_tl, m_th, v, n_tl, n_th;
    logic [3:0] m_tmod;
    bit m_tr, m_tf, p1, p2, ps, fall, pulse, bw, bt, ovf, sw_tf;

    // reference: counter value as an integer, wrapped with plain modular arithmetic
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_tl = 0; m_th = 0; m_tmod = 0; m_tr = 0; m_tf = 0; p1 = 0; p2 = 0; ps = 0;
        end else begin
            fall  = tick && ps && !p2;
            pulse = m_tr && (!m_tmod[3] || int_pin) && (m_tmod[2] ? fall : tick);
            bw = wr_en && !wr_bit_en;
            bt = wr_en && wr_bit_en;
            n_tl = m_tl; n_th = m_th; ovf = 0;
            if (pulse && !(bw && (addr == TL_A || addr == TH_A))) begin
                case (m_tmod[1:0])
                    0: begin
                        v = m_th * 32 + m_tl % 32 + 1; ovf = (v == 8192); v = v % 8192;
                        n_tl = m_tl / 32 * 32 + v % 32; n_th = v / 32;
                    end
                    1: begin
                        v = m_th * 256 + m_tl + 1; ovf = (v == 65536); v = v % 65536;
                        n_tl = v % 256; n_th = v / 256;
                    end
                    2: begin
                        ovf = (m_tl == 255); n_tl = ovf ? m_th : m_tl + 1;
                    end
                    default: ;
                endcase
            end
            if (bw && addr == TL_A) n_tl = data_in;
            if (bw && addr == TH_A) n_th = data_in;
            if (bw && addr == TMOD_A) m_tmod = data_in[4*ID +: 4];
            if (bw && addr == TCON_A) m_tr = data_in[4+2*ID];
            if (bt && addr == TR_A) m_tr = bit_in;
            sw_tf = m_tf;
            if (bw && addr == TCON_A) sw_tf = data_in[5+2*ID];
            if (bt && addr == TF_A) sw_tf = bit_in;
            m_tf = ovf ? 1'b1 : tf_clear ? 1'b0 : sw_tf;
            m_tl = n_tl; m_th = n_th;
            if (tick) ps = p2;
            p2 = p1; p1 = t_pin;
        end
    end

    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("model_tl", tl_data, 8'(m_tl));
        chk("model_th", th_data, 8'(m_th));
        chk("model_tmod", 8'(tmod_nib), 8'(m_tmod));
        chk("model_tr", 8'(tr), 8'(m_tr));
        chk("model_tf", 8'(tf), 8'(m_tf));
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wr_en = 1; wr_bit_en = 0; addr = a; data_in = d;
        step();
        wr_en = 0;
    endtask

    task automatic wbit(input logic [7:0] a, input logic b);
        wr_en = 1; wr_bit_en = 1; addr = a; bit_in = b;
        step();
        wr_en = 0; wr_bit_en = 0;
    endtask

    task automatic tk();
        tick = 1;
        step();
        tick = 0;
        repeat (3) step();
    endtask

    initial begin
        reset = 1;
        #12;
        chk("reset_tl", tl_data, 8'h00);
        chk("reset_tf", 8'(tf), 8'h00);
        step();
        reset = 0;
        step();

        wr(TMOD_A, 8'h10); wr(TH_A, 8'hFF); wr(TL_A, 8'hFE); wbit(TR_A, 1);
        tk();
        chk("m1_tl1", tl_data, 8'hFF); chk("m1_th1", th_data, 8'hFF); chk("m1_tf1", 8'(tf), 8'h00);
        tk();
        chk("m1_tl2", tl_data, 8'h00); chk("m1_th2", th_data, 8'h00); chk("m1_tf2", 8'(tf), 8'h01);
        tf_clear = 1; step(); tf_clear = 0;
        chk("m1_clear", 8'(tf), 8'h00);

        wr(TH_A, 8'hF0); wr(TL_A, 8'hFE); wr(TMOD_A, 8'h20);
        tk(); chk("m2_tl1", tl_data, 8'hFF);
        tk(); chk("m2_tl2", tl_data, 8'hF0); chk("m2_tf", 8'(tf), 8'h01);
        tk(); chk("m2_tl3", tl_data, 8'hF1); chk("m2_th", th_data, 8'hF0);

        wbit(TF_A, 0); wr(TMOD_A, 8'h00); wr(TL_A, 8'hBF); wr(TH_A, 8'hFF);
        tk();
        chk("m0_tl", tl_data, 8'hA0); chk("m0_th", th_data, 8'h00); chk("m0_tf", 8'(tf), 8'h01);

        wr(TMOD_A, 8'h50); wr(TL_A, 8'h00); wr(TH_A, 8'h00);
        repeat (3) begin
            t_pin = 1; repeat (3) tk();
            t_pin = 0; repeat (3) tk();
        end
        chk("ctr_tl", tl_data, 8'h03);
        t_pin = 1; repeat (3) tk();
        t_pin = 0; repeat (6) step();
        chk("ctr_notick", tl_data, 8'h03);
        tk();
        chk("ctr_tick", tl_data, 8'h04);

        wr(TL_A, 8'h00); wr(TH_A, 8'h00); int_pin = 0; wr(TMOD_A, 8'h90);
        repeat (3) tk(); chk("gate_off", tl_data, 8'h00);
        int_pin = 1;
        repeat (3) tk(); chk("gate_on", tl_data, 8'h03);
        wr(TMOD_A, 8'hB0);
        repeat (3) tk(); chk("m3_hold", tl_data, 8'h03);
        wr(TL_A, 8'h77); chk("m3_wr", tl_data, 8'h77);

        wr(TMOD_A, 8'h10); wr(TL_A, 8'h10); wr(TH_A, 8'h22);
        tick = 1; wr(TL_A, 8'h55); tick = 0;
        chk("col_tl", tl_data, 8'h55); chk("col_th", th_data, 8'h22);
        wbit(TF_A, 0); wr(TH_A, 8'hFF); wr(TL_A, 8'hFF);
        tick = 1; tf_clear = 1; step(); tick = 0; tf_clear = 0;
        chk("ovf_vs_clr", 8'(tf), 8'h01);
        wr(TH_A, 8'hFF); wr(TL_A, 8'hFF);
        tick = 1; wbit(TF_A, 0); tick = 0;
        chk("ovf_vs_sw0", 8'(tf), 8'h01);
        tf_clear = 1; wbit(TF_A, 1); tf_clear = 0;
        chk("clr_vs_sw1", 8'(tf), 8'h00);

        wr(TL_A, 8'h10); tick = 1; repeat (3) step();
        #2 reset = 1; #1;
        chk("arst_tl", tl_data, 8'h00); chk("arst_th", th_data, 8'h00);
        chk("arst_tmod", 8'(tmod_nib), 8'h00); chk("arst_tr", 8'(tr), 8'h00); chk("arst_tf", 8'(tf), 8'h00);
        step(); reset = 0; tick = 0; step();

        wr(TMOD_A, 8'h10); wbit(TR_A, 1);
        repeat (4000) begin
            tick = ($urandom % 3) == 0;
            if ($urandom % 5 == 0) t_pin = ~t_pin;
            if ($urandom % 40 == 0) int_pin = ~int_pin;
            tf_clear = ($urandom % 16) == 0;
            wr_en = ($urandom % 6) == 0;
            wr_bit_en = $urandom % 2;
            addr = ADDRS[$urandom % 8];
            data_in = 8'($urandom);
            if (addr == TL_A || addr == TH_A) data_in = data_in | 8'hF0;
            bit_in = ($urandom % 4) != 0;
            step();
        end
        wr_en = 0; tick = 0; tf_clear = 0;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/timer_unit.md
Name: timer_unit

Overview:
- Complete 8051 Timer/Counter channel: TLx/THx counter registers, its TMOD nibble, and its TRx/TFx bits in TCON.
- Sits on the SFR bus beside the other SFR blocks. Timer 0 and Timer 1 are two instances with different parameters.
- Supports timer and counter operation, gated run, 13/16-bit and 8-bit auto-reload modes, and hardware overflow-flag clear on interrupt acknowledge.

Parameters:
- TIMER_ID, 0: channel index. Selects TMOD nibble [4*ID+3:4*ID], TR bit TCON[4+2*ID], TF bit TCON[5+2*ID]. Legal values are 0 and 1.
- TL_ADDR, 8'h8A: direct address of TLx.
- TH_ADDR, 8'h8C: direct address of THx.
- TMOD_ADDR, 8'h89: direct address of TMOD.
- TCON_ADDR, 8'h88: direct address of TCON, and bit-address base of its bits.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- data_in  in  8  SFR write data
- addr  in  8  direct byte address, or bit address when wr_bit_en=1
- wr_en  in  1  SFR write strobe
- wr_bit_en  in  1  qualifies a write as a bit write
- bit_in  in  1  bit-write data
- tick  in  1  machine-cycle enable, one clock wide
- t_pin  in  1  external count input Tx, asynchronous
- int_pin  in  1  gate input INTx, active-high level already synchronised
- tf_clear  in  1  interrupt-acknowledge pulse, clears TF
- tl_data  out  8  TLx contents
- th_data  out  8  THx contents
- tmod_nib  out  4  {GATE, C/T, M1, M0}
- tr  out  1  run control bit
- tf  out  1  overflow flag

Behaviour:
- Reset (asynchronous, immediate):
  - tl_data, th_data, tmod_nib, tr, tf are 0.
  - t_pin synchroniser and edge history are 0.
  - Reset mid-count abandons the count; counting resumes only after release and software setting tr.
- Byte write, when wr_en & !wr_bit_en:
  - addr==TL_ADDR loads TL.
  - addr==TH_ADDR loads TH.
  - addr==TMOD_ADDR loads the nibble from data_in[4*ID+3:4*ID]; other bits are ignored.
  - addr==TCON_ADDR loads tr from data_in[4+2*ID] and tf from data_in[5+2*ID].
- Bit write, when wr_en & wr_bit_en:
  - addr==TCON_ADDR+4+2*ID writes tr.
  - addr==TCON_ADDR+5+2*ID writes tf.
  - All other addresses are ignored.
- All register writes take effect on the next rising clock edge.
- t_pin path:
  - Two-flop synchroniser.
  - A sample register updates only on tick.
  - A falling edge is sample=1 and synced=0 on a tick cycle.
- Count pulse:
  - run = tr & (!GATE | int_pin).
  - pulse = run & (C/T ? falling-edge : tick).
  - At most one increment per clock.
- Modes (M1M0):
  - 00, 13-bit: TL[4:0] is the low part, TH is the high part, TL[7:5] holds. Overflow when TH=FF and TL[4:0]=1F; next value is TL[4:0]=0, TH=0.
  - 01, 16-bit {TH,TL}. Overflow FFFF->0000.
  - 10, 8-bit TL with auto-reload. When TL=FF, TL<=TH on the pulse and it is an overflow. TH never counts.
  - 11: channel halted. TL/TH hold and no overflow occurs; SFR writes still work.
- Overflow sets tf on the same edge as the counter wrap. tf is visible in the following cycle.
- Simultaneous events:
  - A write to TL or TH in a pulse cycle: the write wins and the count is discarded for that cycle, for both registers.
  - Hardware tf set beats both tf_clear and a software tf=0 write in the same cycle.
  - tf_clear beats a software tf=1 write.
  - A TMOD write takes effect for pulses from the next cycle on.
- Outputs are registers and are updated only on clock or reset; no combinational path from inputs to outputs.

Test Plan:
- Mode 1 timer:
  - Stimulus: TMOD=01, TH=FF, TL=FE, set TR by bit write, tick every 4 clocks.
  - Required: tl/th go FF/FF, then 00/00, and tf=1 on the second tick. tf_clear pulse gives tf=0.
- Mode 2 reload:
  - Stimulus: TH=F0, TL=FE, TMOD=02, TR=1.
  - Required: TL goes FE, FF, F0, F1; tf set at the F0 load; TH stays F0.
- Mode 0 13-bit:
  - Stimulus: TL=1F, TH=FF, TL[7:5]=101.
  - Required: one tick gives TL=A0, TH=00, tf=1.
- Counter mode:
  - Stimulus: TMOD=05, t_pin toggled 1->0 three times, each level held for at least 3 ticks.
  - Required: TL=3. A t_pin change with tick=0 alone does not count.
- Gate and mode 3:
  - Stimulus: TMOD=09, int_pin=0, TR=1.
  - Required: no counting. After int_pin=1, counting starts. After TMOD=0B the count freezes.
- Collisions and reset:
  - Stimulus: TL write of 55 in a tick cycle.
  - Required: TL=55 and TH is unchanged.
  - Stimulus: overflow coinciding with tf_clear.
  - Required: tf=1.
  - Stimulus: reset asserted mid-count.
  - Required: all outputs are 0 immediately, with no clock edge needed.
